// File: rtl/nibble_serial_addsub_if.sv
// Request/result bundle between a requester and the nibble-serial add/subtract sequencer.
interface nibble_serial_addsub_if #(
  parameter int unsigned NIBBLES = 4
);
  localparam int unsigned W = 4 * NIBBLES;

  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ready;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;

  modport master (
    output start, sub, a, b,
    input  ready, done, result, cout, ovf
  );

  modport slave (
    input  start, sub, a, b,
    output ready, done, result, cout, ovf
  );
endinterface

// File: rtl/nibble_serial_addsub.sv
// Multi-cycle add/subtract: one 4-bit ripple slice reused once per nibble, LSB nibble first.
// Start/done handshake; subtraction is A + ~B + 1 with the +1 injected as the initial carry.
module nibble_serial_addsub #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  nibble_serial_addsub_if.slave  bus
);
  localparam int unsigned W  = 4 * NIBBLES;
  localparam int unsigned IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t        state_q;
  logic [W-1:0]  a_q;
  logic [W-1:0]  bx_q;
  logic          carry_q;
  logic [IW-1:0] idx_q;
  logic          ready_q;
  logic          done_q;
  logic [W-1:0]  result_q;
  logic          cout_q;
  logic          ovf_q;

  logic [IW+1:0] nib_lo;
  logic [3:0]    nib_x;
  logic [3:0]    nib_y;
  logic [4:0]    slice;
  logic          ovf_next;

  // 4-bit ripple-carry slice: returns {carry_out, sum}
  function automatic logic [4:0] slice_add(input logic [3:0] x, input logic [3:0] y,
                                           input logic z);
    logic       c;
    logic [3:0] s;
    c = z;
    s = 4'h0;
    for (int i = 0; i < 4; i++) begin
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    return {c, s};
  endfunction

  // Current nibble select and slice evaluation
  always_comb begin
    nib_lo   = {idx_q, 2'b00};
    nib_x    = a_q[nib_lo +: 4];
    nib_y    = bx_q[nib_lo +: 4];
    slice    = slice_add(nib_x, nib_y, carry_q);
    ovf_next = (a_q[W-1] == bx_q[W-1]) && (slice[3] != a_q[W-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      bx_q     <= '0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_q     <= bus.a;
            bx_q    <= bus.sub ? ~bus.b : bus.b;
            carry_q <= bus.sub;
            idx_q   <= '0;
            ready_q <= 1'b0;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          result_q[nib_lo +: 4] <= slice[3:0];
          carry_q               <= slice[4];
          if (idx_q == LAST_IDX) begin
            // Final nibble: flags are valid alongside the done pulse
            idx_q   <= '0;
            done_q  <= 1'b1;
            cout_q  <= slice[4];
            ovf_q   <= ovf_next;
            state_q <= ST_DONE;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ready  = ready_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.cout   = cout_q;
  assign bus.ovf    = ovf_q;

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Self-checking bench for nibble_serial_addsub: vector table, random ops vs. arithmetic model,
// and hand-written sequences for abort, ignored start and back-to-back operation.
module tb_nibble_serial_addsub;
  localparam int unsigned NIBBLES = 4;
  localparam int unsigned W       = 4 * NIBBLES;
  localparam int          LAT     = NIBBLES + 1;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  nibble_serial_addsub_if #(.NIBBLES(NIBBLES)) bus ();

  nibble_serial_addsub #(.NIBBLES(NIBBLES)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] res;
    logic         cout;
    logic         ovf;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Arithmetic reference: integer sum modulo 2^W, carry from bit W, signed overflow by sign rule
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                       output logic [W-1:0] res, output logic cout, output logic ovf);
    logic [W:0] full;
    longint     sa, sb, sr;
    if (sub) full = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
    else     full = {1'b0, a} + {1'b0, b};
    res  = full[W-1:0];
    cout = full[W];
    sa = a[W-1] ? longint'(a) - (64'sd1 <<< W) : longint'(a);
    sb = b[W-1] ? longint'(b) - (64'sd1 <<< W) : longint'(b);
    sr = sub ? sa - sb : sa + sb;
    ovf = (sr > ((64'sd1 <<< (W-1)) - 1)) || (sr < -(64'sd1 <<< (W-1)));
  endtask

  // Issue one operation, wait (bounded) for done, return outputs and measured latency
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                        output logic [W-1:0] res, output logic cout, output logic ovf,
                        output int lat);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.sub   = sub;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = $urandom();
    bus.b     = $urandom();
    lat = 1;
    while (!bus.done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    res  = bus.result;
    cout = bus.cout;
    ovf  = bus.ovf;
  endtask

  vec_t         vecs[6];
  logic [W-1:0] r;
  logic         c, o;
  logic [W-1:0] er;
  logic         ec, eo;
  int           lat;
  int           done_cnt;
  int           cyc;
  int           last_done;

  initial begin
    checks    = 0;
    failures  = 0;
    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    rst_n     = 1'b0;

    vecs[0] = '{a: 16'h00FF, b: 16'h0001, sub: 1'b0, res: 16'h0100, cout: 1'b0, ovf: 1'b0};
    vecs[1] = '{a: 16'hFFFF, b: 16'h0001, sub: 1'b0, res: 16'h0000, cout: 1'b1, ovf: 1'b0};
    vecs[2] = '{a: 16'h7FFF, b: 16'h0001, sub: 1'b0, res: 16'h8000, cout: 1'b0, ovf: 1'b1};
    vecs[3] = '{a: 16'h8000, b: 16'h0001, sub: 1'b1, res: 16'h7FFF, cout: 1'b1, ovf: 1'b1};
    vecs[4] = '{a: 16'h0005, b: 16'h0007, sub: 1'b1, res: 16'hFFFE, cout: 1'b0, ovf: 1'b0};
    vecs[5] = '{a: 16'h1234, b: 16'h1234, sub: 1'b1, res: 16'h0000, cout: 1'b1, ovf: 1'b0};

    // Reset state
    #23;
    check("rst_ready",  32'(bus.ready),  32'd1);
    check("rst_done",   32'(bus.done),   32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_cout",   32'(bus.cout),   32'd0);
    check("rst_ovf",    32'(bus.ovf),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors
    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].sub, r, c, o, lat);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(LAT));
      check($sformatf("vec%0d_result", i), 32'(r), 32'(vecs[i].res));
      check($sformatf("vec%0d_cout", i), 32'(c), 32'(vecs[i].cout));
      check($sformatf("vec%0d_ovf", i), 32'(o), 32'(vecs[i].ovf));
      @(negedge clk);
      check($sformatf("vec%0d_ready_after", i), 32'(bus.ready), 32'd1);
      check($sformatf("vec%0d_done_single", i), 32'(bus.done), 32'd0);
      check($sformatf("vec%0d_result_held", i), 32'(bus.result), 32'(vecs[i].res));
    end

    // Randomized operations against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      logic         rs;
      ra = W'($urandom());
      rb = W'($urandom());
      rs = 1'($urandom_range(0, 1));
      if (i % 8 == 0) ra = {1'b0, {(W-1){1'b1}}};
      if (i % 8 == 1) rb = {1'b1, {(W-1){1'b0}}};
      model(ra, rb, rs, er, ec, eo);
      run_op(ra, rb, rs, r, c, o, lat);
      check($sformatf("rnd%0d_latency", i), 32'(lat), 32'(LAT));
      check($sformatf("rnd%0d_result", i), 32'(r), 32'(er));
      check($sformatf("rnd%0d_cout", i), 32'(c), 32'(ec));
      check($sformatf("rnd%0d_ovf", i), 32'(o), 32'(eo));
    end

    // Start pulsed during RUN cycle 2 is ignored
    @(negedge clk);
    bus.start = 1'b1; bus.a = 16'h0003; bus.b = 16'h0001; bus.sub = 1'b0;
    @(negedge clk);                          // cycle 1
    bus.start = 1'b0;
    @(negedge clk);                          // cycle 2
    bus.start = 1'b1; bus.a = 16'h1234; bus.b = 16'h1111;
    @(negedge clk);                          // cycle 3
    bus.start = 1'b0;
    @(negedge clk);                          // cycle 4
    check("ign_no_early_done", 32'(bus.done), 32'd0);
    @(negedge clk);                          // cycle 5
    check("ign_done", 32'(bus.done), 32'd1);
    check("ign_result", 32'(bus.result), 32'h0004);
    done_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    check("ign_no_second_done", 32'(done_cnt), 32'd0);
    check("ign_result_held", 32'(bus.result), 32'h0004);

    // Asynchronous reset in RUN cycle 3 aborts the operation
    @(negedge clk);
    bus.start = 1'b1; bus.a = 16'h1111; bus.b = 16'h2222; bus.sub = 1'b0;
    @(negedge clk);                          // cycle 1
    bus.start = 1'b0;
    @(negedge clk);                          // cycle 2
    @(negedge clk);                          // cycle 3
    rst_n = 1'b0;
    #1;
    check("abort_ready",  32'(bus.ready),  32'd1);
    check("abort_done",   32'(bus.done),   32'd0);
    check("abort_result", 32'(bus.result), 32'd0);
    check("abort_cout",   32'(bus.cout),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    check("abort_no_done", 32'(done_cnt), 32'd0);
    run_op(16'h1111, 16'h2222, 1'b0, r, c, o, lat);
    check("abort_rerun_latency", 32'(lat), 32'(LAT));
    check("abort_rerun_result", 32'(r), 32'h3333);

    // start held high: back-to-back operations every NIBBLES+2 cycles
    @(negedge clk);
    @(negedge clk);
    bus.start = 1'b1; bus.a = 16'h0001; bus.b = 16'h0001; bus.sub = 1'b0;
    done_cnt  = 0;
    last_done = -1;
    cyc       = 0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      cyc++;
      if (bus.done) begin
        if (last_done < 0) check("b2b_first_latency", 32'(cyc), 32'(LAT));
        else check($sformatf("b2b_interval%0d", done_cnt), 32'(cyc - last_done), 32'(NIBBLES + 2));
        check($sformatf("b2b_result%0d", done_cnt), 32'(bus.result), 32'h0002);
        last_done = cyc;
        done_cnt++;
      end
    end
    bus.start = 1'b0;
    check("b2b_done_count", 32'(done_cnt), 32'd5);

    repeat (10) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the bench always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
